// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC-update sequencer: state enum, mux/cause/ALU codes
// and the opcode/funct decode tables.
package pc_seq_pkg;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_MEM_WAIT   = 4'd1,
      S_IR_LOAD    = 4'd2,
      S_DECODE     = 4'd3,
      S_JR         = 4'd4,
      S_BRANCH     = 4'd5,
      S_JUMP       = 4'd6,
      S_JAL        = 4'd7,
      S_RTE        = 4'd8,
      S_EXEC_ARITH = 4'd9,
      S_EXEC_OTHER = 4'd10,
      S_EXC_SAVE   = 4'd11,
      S_EXC_READ   = 4'd12,
      S_EXC_LOAD   = 4'd13
   } state_e;

   localparam logic [2:0] PCSRC_JUMP   = 3'b000;
   localparam logic [2:0] PCSRC_ALU    = 3'b001;
   localparam logic [2:0] PCSRC_ALUOUT = 3'b010;
   localparam logic [2:0] PCSRC_MEM    = 3'b011;
   localparam logic [2:0] PCSRC_EPC    = 3'b100;

   localparam logic [1:0] IORD_PC  = 2'b00;
   localparam logic [1:0] IORD_VEC = 2'b01;

   localparam logic [1:0] EXC_INVALID  = 2'b00;
   localparam logic [1:0] EXC_OVERFLOW = 2'b01;
   localparam logic [1:0] EXC_DIVZERO  = 2'b10;

   localparam logic [1:0] ALU_IDLE   = 2'b00;
   localparam logic [1:0] ALU_PC_INC = 2'b01;
   localparam logic [1:0] ALU_BR_TGT = 2'b10;
   localparam logic [1:0] ALU_PC_DEC = 2'b11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_RTE   = 6'h10;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;

   // R-type functs handled by main control (jr/add/sub have their own paths)
   function automatic logic is_valid_funct(input logic [5:0] f);
      case (f)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h10, 6'h12, 6'h18, 6'h1A,
         6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_other_opcode(input logic [5:0] op);
      case (op)
         6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
         6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pc_seq_wait_ctr.sv
// Loadable down-counter pacing the instruction-fetch and exception-vector memory waits.
module pc_seq_wait_ctr (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [2:0] load_val_i,
   input  logic       dec_i,
   output logic       last_o
);

   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Final wait cycle: the decrement taken now brings the count to zero.
   assign last_o = (cnt_q <= 3'd1);

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle sequencer for the PC/EPC update path: fetch, branch/jump/jr/rte, exception entry,
// and hand-off of other ops to main control via exec_req/exec_done.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   input  logic       div_zero,
   input  logic       exec_done,
   output logic       exec_req,
   output logic [2:0] PCSource,
   output logic       PCWrite,
   output logic       EPCWrite,
   output logic       IRWrite,
   output logic       MemRead,
   output logic [1:0] IorD,
   output logic [1:0] ExcCause,
   output logic [1:0] alu_op,
   output logic       LinkWrite,
   output logic [3:0] state_dbg
);

   localparam logic [2:0] WAIT_FETCH = 3'(MEM_LATENCY - 1);
   localparam logic [2:0] WAIT_EXC   = 3'(MEM_LATENCY);

   state_e     state_q, state_d;
   logic [1:0] exc_cause_q, exc_cause_d;
   logic       ctr_load, ctr_dec, ctr_last, br_take;
   logic [2:0] ctr_val;

   pc_seq_wait_ctr u_wait_ctr (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (ctr_load),
      .load_val_i (ctr_val),
      .dec_i      (ctr_dec),
      .last_o     (ctr_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         exc_cause_q <= EXC_INVALID;
      end else begin
         state_q     <= state_d;
         exc_cause_q <= exc_cause_d;
      end
   end

   assign ctr_dec   = (state_q == S_MEM_WAIT) || (state_q == S_EXC_READ);
   assign ExcCause  = exc_cause_q;
   assign state_dbg = state_q;

   // Decoded outputs are forced low while reset is high so they drop without a clock edge.
   always_comb begin
      state_d     = state_q;
      exc_cause_d = exc_cause_q;
      exec_req    = 1'b0;
      PCSource    = PCSRC_JUMP;
      PCWrite     = 1'b0;
      EPCWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      IorD        = IORD_PC;
      alu_op      = ALU_IDLE;
      LinkWrite   = 1'b0;
      ctr_load    = 1'b0;
      ctr_val     = '0;
      br_take     = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               MemRead  = 1'b1;
               IorD     = IORD_PC;
               alu_op   = ALU_PC_INC;
               ctr_load = 1'b1;
               ctr_val  = WAIT_FETCH;
               state_d  = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
               MemRead = 1'b1;
               if (ctr_last) state_d = S_IR_LOAD;
            end
            S_IR_LOAD: begin
               IRWrite  = 1'b1;
               PCSource = PCSRC_ALU;
               PCWrite  = 1'b1;
               state_d  = S_DECODE;
            end
            S_DECODE: begin
               alu_op = ALU_BR_TGT;
               if (opcode == OP_RTYPE) begin
                  if (funct == FN_JR) begin
                     state_d = S_JR;
                  end else if ((funct == FN_ADD) || (funct == FN_SUB)) begin
                     state_d = S_EXEC_ARITH;
                  end else if (is_valid_funct(funct)) begin
                     state_d = S_EXEC_OTHER;
                  end else begin
                     state_d     = S_EXC_SAVE;
                     exc_cause_d = EXC_INVALID;
                  end
               end else begin
                  case (opcode)
                     OP_BEQ, OP_BNE: state_d = S_BRANCH;
                     OP_J:           state_d = S_JUMP;
                     OP_JAL:         state_d = S_JAL;
                     OP_ADDI:        state_d = S_EXEC_ARITH;
                     OP_RTE:         state_d = S_RTE;
                     default: begin
                        if (is_other_opcode(opcode)) begin
                           state_d = S_EXEC_OTHER;
                        end else begin
                           state_d     = S_EXC_SAVE;
                           exc_cause_d = EXC_INVALID;
                        end
                     end
                  endcase
               end
            end
            S_JR: begin
               PCSource = PCSRC_ALU;
               PCWrite  = 1'b1;
               state_d  = S_FETCH;
            end
            S_BRANCH: begin
               br_take  = (opcode == OP_BEQ) ? zero : !zero;
               PCWrite  = br_take;
               PCSource = br_take ? PCSRC_ALUOUT : PCSRC_JUMP;
               state_d  = S_FETCH;
            end
            S_JUMP: begin
               PCSource = PCSRC_JUMP;
               PCWrite  = 1'b1;
               state_d  = S_FETCH;
            end
            S_JAL: begin
               PCSource  = PCSRC_JUMP;
               PCWrite   = 1'b1;
               LinkWrite = 1'b1;
               state_d   = S_FETCH;
            end
            S_RTE: begin
               PCSource = PCSRC_EPC;
               PCWrite  = 1'b1;
               state_d  = S_FETCH;
            end
            S_EXEC_ARITH: begin
               exec_req = 1'b1;
               if (overflow) begin
                  state_d     = S_EXC_SAVE;
                  exc_cause_d = EXC_OVERFLOW;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_EXEC_OTHER: begin
               exec_req = 1'b1;
               if (exec_done) begin
                  if (div_zero) begin
                     state_d     = S_EXC_SAVE;
                     exc_cause_d = EXC_DIVZERO;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
            S_EXC_SAVE: begin
               alu_op   = ALU_PC_DEC;
               EPCWrite = 1'b1;
               ctr_load = 1'b1;
               ctr_val  = WAIT_EXC;
               state_d  = S_EXC_READ;
            end
            S_EXC_READ: begin
               MemRead = 1'b1;
               IorD    = IORD_VEC;
               if (ctr_last) state_d = S_EXC_LOAD;
            end
            S_EXC_LOAD: begin
               PCSource = PCSRC_MEM;
               PCWrite  = 1'b1;
               state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule
